// File: rtl/vote_pkg.sv
// Shared definitions for the vote logger: FSM encoding, candidate and
// counter dimensions, and a small one-hot to index helper.
package vote_pkg;

    localparam int NUM_CANDIDATES = 4;
    localparam int COUNT_W        = 8;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        CAST         = 2'd1,
        LOCKOUT      = 2'd2,
        WAIT_RELEASE = 2'd3
    } vote_state_e;

    // Index of the single set bit; only meaningful for one-hot inputs.
    function automatic logic [1:0] onehot_index(input logic [NUM_CANDIDATES-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        case (v)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer followed by a stability counter. The debounced
// level only follows the synchronized input after it has disagreed for
// DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic level
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] stable_cnt;

    // Bring the asynchronous raw button into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Count consecutive disagreement cycles and flip the level on the last one.
    always_ff @(posedge clock) begin
        if (reset) begin
            stable_cnt <= '0;
            level      <= 1'b0;
        end else if (sync2 != level) begin
            if (stable_cnt == CNT_LAST) begin
                stable_cnt <= '0;
                level      <= sync2;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end else begin
            stable_cnt <= '0;
        end
    end

endmodule

// File: rtl/vote_logger.sv
// Four-candidate vote logger. Debounced buttons feed a small FSM that
// accepts exactly one vote per press, enforces a post-vote lockout and
// waits for all buttons to be released before arming again.
// The current FSM state is exported on fsm_state for observation.
module vote_logger
    import vote_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LOCKOUT_CYCLES  = 100000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               mode,
    input  logic               button1,
    input  logic               button2,
    input  logic               button3,
    input  logic               button4,
    output logic [COUNT_W-1:0] candidate1_vote,
    output logic [COUNT_W-1:0] candidate2_vote,
    output logic [COUNT_W-1:0] candidate3_vote,
    output logic [COUNT_W-1:0] candidate4_vote,
    output logic               candidate1_button_press,
    output logic               candidate2_button_press,
    output logic               candidate3_button_press,
    output logic               candidate4_button_press,
    output logic               valid_vote_casted,
    output logic               busy,
    output vote_state_e        fsm_state
);

    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_CANDIDATES-1:0] raw;
    logic [NUM_CANDIDATES-1:0] level;
    logic [COUNT_W-1:0]        votes [NUM_CANDIDATES];
    logic [1:0]                sel;
    logic [LOCK_W-1:0]         lock_cnt;
    logic                      one_pressed;
    logic                      many_pressed;
    vote_state_e               state;
    vote_state_e               next_state;

    assign raw = {button4, button3, button2, button1};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CANDIDATES; gi++) begin : g_deb
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .clock (clock),
                .reset (reset),
                .button(raw[gi]),
                .level (level[gi])
            );
        end
    endgenerate

    assign one_pressed  = (level != '0) && ((level & (level - 1'b1)) == '0);
    assign many_pressed = (level != '0) && !one_pressed;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state logic; mode is only consulted while idle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!mode) begin
                    if (one_pressed)       next_state = CAST;
                    else if (many_pressed) next_state = WAIT_RELEASE;
                end
            end
            CAST:         next_state = LOCKOUT;
            LOCKOUT:      if (lock_cnt == LOCK_LAST) next_state = WAIT_RELEASE;
            WAIT_RELEASE: if (level == '0) next_state = IDLE;
            default:      next_state = IDLE;
        endcase
    end

    // Latch the chosen candidate as the FSM leaves IDLE for CAST.
    always_ff @(posedge clock) begin
        if (reset)                                    sel <= 2'd0;
        else if (state == IDLE && next_state == CAST) sel <= onehot_index(level);
    end

    // Lockout cycle counter, held at zero outside LOCKOUT.
    always_ff @(posedge clock) begin
        if (reset || state != LOCKOUT) lock_cnt <= '0;
        else                           lock_cnt <= lock_cnt + 1'b1;
    end

    // Saturating vote totals, updated only in CAST.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CANDIDATES; i++) votes[i] <= '0;
        end else if (state == CAST && votes[sel] != COUNT_MAX) begin
            votes[sel] <= votes[sel] + 1'b1;
        end
    end

    assign valid_vote_casted = (state == CAST);
    assign busy              = (state != IDLE);
    assign fsm_state         = state;

    assign candidate1_vote = votes[0];
    assign candidate2_vote = votes[1];
    assign candidate3_vote = votes[2];
    assign candidate4_vote = votes[3];

    assign candidate1_button_press = level[0];
    assign candidate2_button_press = level[1];
    assign candidate3_button_press = level[2];
    assign candidate4_button_press = level[3];

endmodule

// File: tb/tb_vote_logger.sv
// Directed bench for vote_logger with short debounce and lockout periods.
module tb_vote_logger;
    import vote_pkg::*;

    localparam int DEB  = 4;
    localparam int LOCK = 10;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mode  = 1'b0;
    logic        button1 = 1'b0, button2 = 1'b0, button3 = 1'b0, button4 = 1'b0;
    logic [7:0]  c1, c2, c3, c4;
    logic        p1, p2, p3, p4;
    logic        valid_vote_casted;
    logic        busy;
    vote_state_e fsm_state;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int base;

    vote_logger #(.DEBOUNCE_CYCLES(DEB), .LOCKOUT_CYCLES(LOCK)) dut (
        .clock(clock), .reset(reset), .mode(mode),
        .button1(button1), .button2(button2), .button3(button3), .button4(button4),
        .candidate1_vote(c1), .candidate2_vote(c2),
        .candidate3_vote(c3), .candidate4_vote(c4),
        .candidate1_button_press(p1), .candidate2_button_press(p2),
        .candidate3_button_press(p3), .candidate4_button_press(p4),
        .valid_vote_casted(valid_vote_casted), .busy(busy), .fsm_state(fsm_state)
    );

    // Clock
    always #5 clock = ~clock;

    // Pulse monitor, sampled away from the active edge.
    always @(negedge clock) if (valid_vote_casted) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
    endtask

    task automatic wait_pulse(input string tag);
        int n;
        n = 0;
        while (!valid_vote_casted && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_pulse_timeout"}, 32'(valid_vote_casted), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((fsm_state != IDLE || {p4, p3, p2, p1} != 4'b0) && n < 200) begin
            @(negedge clock);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
    endtask

    task automatic set_btn(input int idx, input logic v);
        case (idx)
            1: button1 = v;
            2: button2 = v;
            3: button3 = v;
            default: button4 = v;
        endcase
    endtask

    // One clean vote: press until the pulse, release, return to idle.
    task automatic vote(input int idx, input string tag);
        set_btn(idx, 1'b1);
        @(negedge clock);
        wait_pulse(tag);
        @(negedge clock);
        set_btn(idx, 1'b0);
        wait_idle(tag);
    endtask

    initial begin
        // Reset state
        cycles(3);
        check("rst_c1", 32'(c1), 0);
        check("rst_c4", 32'(c4), 0);
        check("rst_valid", 32'(valid_vote_casted), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check("rst_press", 32'({p4, p3, p2, p1}), 0);
        reset = 1'b0;
        cycles(2);

        // Clean hold of button2 for 20 cycles: exactly one vote.
        base = pulses;
        button2 = 1'b1;
        cycles(20);
        check("hold_press2", 32'(p2), 1);
        button2 = 1'b0;
        wait_idle("hold");
        check("hold_pulses", 32'(pulses - base), 1);
        check("hold_c2", 32'(c2), 1);
        check("hold_others", 32'({c1, c3, c4}), 0);

        // Bouncing button1, then stable high.
        do_reset();
        base = pulses;
        button1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycles(2);
            button1 = ~button1;
        end
        button1 = 1'b1;
        check("bounce_no_pulse", 32'(pulses - base), 0);
        check("bounce_no_level", 32'(p1), 0);
        wait_pulse("bounce");
        @(negedge clock);
        button1 = 1'b0;
        wait_idle("bounce");
        check("bounce_pulses", 32'(pulses - base), 1);
        check("bounce_c1", 32'(c1), 1);

        // Two buttons together: no vote, busy until released.
        do_reset();
        base = pulses;
        button1 = 1'b1;
        button3 = 1'b1;
        cycles(12);
        check("multi_busy", 32'(busy), 1);
        check("multi_state", 32'(fsm_state), 32'(WAIT_RELEASE));
        cycles(10);
        check("multi_busy_held", 32'(busy), 1);
        button1 = 1'b0;
        button3 = 1'b0;
        wait_idle("multi");
        check("multi_pulses", 32'(pulses - base), 0);
        check("multi_counts", 32'({c1, c2, c3, c4}), 0);

        // Re-press during lockout is ignored.
        do_reset();
        base = pulses;
        button2 = 1'b1;
        @(negedge clock);
        wait_pulse("lock");
        @(negedge clock);
        button2 = 1'b0;
        cycles(4);
        check("lock_state", 32'(fsm_state), 32'(LOCKOUT));
        button2 = 1'b1;
        cycles(3);
        button2 = 1'b0;
        check("lock_still", 32'(fsm_state), 32'(LOCKOUT));
        wait_idle("lock");
        cycles(10);
        check("lock_pulses", 32'(pulses - base), 1);
        check("lock_c2", 32'(c2), 1);

        // Saturation of candidate4.
        do_reset();
        base = pulses;
        for (int i = 1; i <= 256; i++) begin
            vote(4, "sat");
            if (i == 254) check("sat_c4_254", 32'(c4), 254);
            if (i == 255) check("sat_c4_255", 32'(c4), 255);
        end
        check("sat_c4_256", 32'(c4), 255);
        check("sat_pulses", 32'(pulses - base), 256);
        check("sat_others", 32'({c1, c2, c3}), 0);

        // Result mode: level visible, no vote.
        do_reset();
        base = pulses;
        mode = 1'b1;
        button3 = 1'b1;
        cycles(15);
        check("mode_press3", 32'(p3), 1);
        check("mode_busy", 32'(busy), 0);
        check("mode_pulses", 32'(pulses - base), 0);
        check("mode_counts", 32'({c1, c2, c3, c4}), 0);
        button3 = 1'b0;
        cycles(10);
        mode = 1'b0;

        // Reset in the middle of lockout after a vote.
        vote(3, "midlock_pre");
        check("midlock_c3_pre", 32'(c3), 1);
        button1 = 1'b1;
        @(negedge clock);
        wait_pulse("midlock");
        @(negedge clock);
        button1 = 1'b0;
        cycles(3);
        check("midlock_in_lock", 32'(fsm_state), 32'(LOCKOUT));
        check("midlock_c1_pre", 32'(c1), 1);
        reset = 1'b1;
        @(negedge clock);
        check("midlock_state", 32'(fsm_state), 32'(IDLE));
        check("midlock_counts", 32'({c1, c2, c3, c4}), 0);
        check("midlock_busy", 32'(busy), 0);
        reset = 1'b0;
        cycles(20);
        check("midlock_after", 32'({c1, c2, c3, c4}), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vote_logger.md
VOTE_LOGGER -- requirements
Module: vote_logger

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, is the number of cycles a synchronized button must stay stable before its debounced level changes (10 ms at 100 MHz).
REQ-002 Parameter LOCKOUT_CYCLES, default 100000000, is the number of post-vote cycles during which no further vote is accepted.
REQ-003 clock  input  1  system clock; all logic rising-edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 mode  input  1  0 = voting mode, 1 = result mode.
REQ-006 button1..button4  input  1 each  raw, asynchronous, bouncing candidate push-buttons.
REQ-007 candidate1_vote..candidate4_vote  output  8 each  registered per-candidate vote totals.
REQ-008 candidate1_button_press..candidate4_button_press  output  1 each  debounced button levels, used downstream for result selection.
REQ-009 valid_vote_casted  output  1  one-cycle pulse per accepted vote.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 Each raw button shall pass through a 2-flop synchronizer before any other use.
REQ-012 A debounced level shall change only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch shorter than that restarts the count.
REQ-013 FSM states: IDLE, CAST, LOCKOUT, WAIT_RELEASE.
REQ-014 IDLE, mode==0, exactly one debounced button high -> CAST.
REQ-015 IDLE, mode==0, two or more debounced buttons high -> WAIT_RELEASE; no vote is counted.
REQ-016 IDLE, mode==1 -> remain in IDLE; no count changes and no pulse, regardless of buttons.
REQ-017 CAST lasts one cycle: the selected candidate's count increments, valid_vote_casted is high for that cycle only, then -> LOCKOUT.
REQ-018 The selected candidate shall be latched on the IDLE->CAST transition; button changes during CAST do not alter it.
REQ-019 Counts shall saturate at 8'hFF; a vote for a saturated candidate still pulses valid_vote_casted, and the count holds at 255.
REQ-020 LOCKOUT shall last exactly LOCKOUT_CYCLES cycles, then -> WAIT_RELEASE.
REQ-021 Mode changes and button activity during LOCKOUT are ignored.
REQ-022 WAIT_RELEASE -> IDLE on the first cycle in which all four debounced levels are low, so a held button yields exactly one vote.
REQ-023 Latency from a debounced rising edge to the valid_vote_casted pulse shall be 2 cycles: IDLE sample, then CAST.
REQ-024 Counts change only in CAST or on reset; mode has no effect on stored totals.
REQ-025 candidateN_button_press shall equal the debounced level in every state and mode.

Reset
REQ-026 On reset, all counts shall be 0, valid_vote_casted shall be 0, busy shall be 0, the FSM shall enter IDLE, and the debounce and lockout counters shall clear.
REQ-027 On reset, synchronizer flops and debounced levels shall clear to 0.
REQ-028 Reset asserted mid-LOCKOUT or mid-CAST shall abort the operation with no partial increment surviving.

Structure
REQ-029 The shared package vote_pkg shall hold the FSM state encoding, the candidate count (4), the count width (8), and the saturation value (8'hFF).
REQ-030 Debouncing shall be implemented in one sub-module, button_debouncer (synchronizer plus stability counter, parameterized by DEBOUNCE_CYCLES), instantiated four times.
REQ-031 The lockout counter shall be 27 bits minimum at the default LOCKOUT_CYCLES and derived via $clog2 from the parameter.

Verification (bench: DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=10)
REQ-032 Hold button2 clean for 20 cycles in mode 0 -> exactly one valid_vote_casted pulse; candidate2_vote=1; all other counts 0.
REQ-033 Toggle button1 every 2 cycles for 12 cycles, then hold high -> no vote during the bounce; exactly one vote after a stable period of 4 cycles; candidate1_vote=1.
REQ-034 Press button1 and button3 together -> no pulse; all counts 0; busy stays high until both are released.
REQ-035 Cast 256 votes for candidate4 -> candidate4_vote=255 after the 255th and 256th votes; 256 pulses are seen.
REQ-036 Press button2 again 5 cycles into LOCKOUT and release before LOCKOUT ends -> no second vote; candidate2_vote stays 1.
REQ-037 Set mode=1 and press button3 -> candidate3_button_press=1, no pulse, counts unchanged; then assert reset mid-LOCKOUT after a vote -> all counts 0 and FSM in IDLE the next cycle.
